ram_port_arbiter: RTL and testbench



---
 rtl/k_and_s_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 25 ++
 rtl/ram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types for the data RAM port arbiter: FSM states, owner encoding and
// the captured request record.
package k_and_s_pkg;

  localparam int unsigned MEM_ADDR_W  = 5;
  localparam int unsigned MEM_DATA_W  = 16;
  localparam int unsigned MAX_RAM_LAT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // Grant vector bit 1 is the debug port, bit 0 the CPU.
  function automatic owner_t owner_of(input logic [1:0] gnt);
    return gnt[1] ? OWN_DBG : OWN_CPU;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; debug can be forced to win a tie while the CPU
// is halted. Purely combinational, one-hot (or zero) grant.
module rr_arb2
  import k_and_s_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  input  logic       force_dbg,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (force_dbg || last_owner == OWN_CPU) gnt = 2'b10;
        else                                    gnt = 2'b01;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous data RAM port between the CPU datapath and the
// debug/loader port. Every output is driven straight from a flop.
module ram_port_arbiter
  import k_and_s_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              cpu_halt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_q, last_d;
  logic [2:0]  cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  mem_req_t    cpu_fields, dbg_fields;
  logic [1:0]  pick;

  logic              ram_en_d, ram_we_d, busy_d;
  logic              cpu_gnt_d, dbg_gnt_d, cpu_rvalid_d, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_d, dbg_rdata_d;

  assign cpu_fields = '{we: cpu_we, addr: MEM_ADDR_W'(cpu_addr), wdata: MEM_DATA_W'(cpu_wdata)};
  assign dbg_fields = '{we: dbg_we, addr: MEM_ADDR_W'(dbg_addr), wdata: MEM_DATA_W'(dbg_wdata)};

  rr_arb2 u_rr_arb2 (
    .req        ({dbg_req, cpu_req}),
    .last_owner (last_q),
    .force_dbg  (cpu_halt),
    .gnt        (pick)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    dbg_rdata_d  = dbg_rdata;

    case (state_q)
      IDLE: begin
        // Outputs registered here become visible during the ACCESS cycle.
        if (|pick) begin
          owner_d   = owner_of(pick);
          last_d    = owner_of(pick);
          req_d     = pick[1] ? dbg_fields : cpu_fields;
          ram_en_d  = 1'b1;
          ram_we_d  = req_d.we;
          cpu_gnt_d = pick[0];
          dbg_gnt_d = pick[1];
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (req_q.we) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 3'(RAM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          if (owner_q == OWN_DBG) begin
            dbg_rdata_d  = ram_rdata;
            dbg_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = ram_rdata;
            cpu_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      last_q     <= OWN_DBG;
      cnt_q      <= '0;
      req_q      <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      ram_en     <= ram_en_d;
      ram_we     <= ram_we_d;
      busy       <= busy_d;
      cpu_gnt    <= cpu_gnt_d;
      dbg_gnt    <= dbg_gnt_d;
      cpu_rvalid <= cpu_rvalid_d;
      dbg_rvalid <= dbg_rvalid_d;
      cpu_rdata  <= cpu_rdata_d;
      dbg_rdata  <= dbg_rdata_d;
    end
  end

  // Address and write data stay on the port after ACCESS; only ram_en qualifies them.
  assign ram_addr  = ADDR_W'(req_q.addr);
  assign ram_wdata = DATA_W'(req_q.wdata);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at RAM_LAT=1, one at
// RAM_LAT=3, each with its own behavioural RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // RAM_LAT = 1 instance
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, cpu_halt = 0;
  logic [4:0]  cpu_addr = '0, dbg_addr = '0;
  logic [15:0] cpu_wdata = '0, dbg_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, ram_en, ram_we, busy;
  logic [15:0] cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
  logic [4:0]  ram_addr;

  // RAM_LAT = 3 instance
  logic        l3_cpu_req = 0, l3_cpu_we = 0, l3_dbg_req = 0, l3_dbg_we = 0, l3_halt = 0;
  logic [4:0]  l3_cpu_addr = '0, l3_dbg_addr = '0;
  logic [15:0] l3_cpu_wdata = '0, l3_dbg_wdata = '0;
  logic        l3_cpu_gnt, l3_cpu_rvalid, l3_dbg_gnt, l3_dbg_rvalid, l3_ram_en, l3_ram_we, l3_busy;
  logic [15:0] l3_cpu_rdata, l3_dbg_rdata, l3_ram_wdata, l3_ram_rdata;
  logic [4:0]  l3_ram_addr;

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(16), .RAM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .cpu_halt(cpu_halt), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(16), .RAM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
    .cpu_gnt(l3_cpu_gnt), .cpu_rvalid(l3_cpu_rvalid), .cpu_rdata(l3_cpu_rdata),
    .dbg_req(l3_dbg_req), .dbg_we(l3_dbg_we), .dbg_addr(l3_dbg_addr), .dbg_wdata(l3_dbg_wdata),
    .dbg_gnt(l3_dbg_gnt), .dbg_rvalid(l3_dbg_rvalid), .dbg_rdata(l3_dbg_rdata),
    .cpu_halt(l3_halt), .ram_en(l3_ram_en), .ram_we(l3_ram_we), .ram_addr(l3_ram_addr),
    .ram_wdata(l3_ram_wdata), .ram_rdata(l3_ram_rdata), .busy(l3_busy)
  );

  // Behavioural synchronous RAMs with a preload back door.
  logic        pl_en = 0, pl3_en = 0;
  logic [4:0]  pl_addr = '0, pl3_addr = '0;
  logic [15:0] pl_data = '0, pl3_data = '0;
  logic [15:0] mem  [32];
  logic [15:0] mem3 [32];
  logic [15:0] rd1;
  logic [15:0] rd3_a, rd3_b, rd3_c;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) rd1 <= mem[ram_addr];
  end
  assign ram_rdata = rd1;

  always @(posedge clk) begin
    if (pl3_en) mem3[pl3_addr] <= pl3_data;
    else if (l3_ram_en && l3_ram_we) mem3[l3_ram_addr] <= l3_ram_wdata;
    if (l3_ram_en && !l3_ram_we) rd3_a <= mem3[l3_ram_addr];
    rd3_b <= rd3_a;
    rd3_c <= rd3_b;
  end
  assign l3_ram_rdata = rd3_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pl_en = 1'b1; pl_addr = 5'd5; pl_data = 16'hBEEF;
    pl3_en = 1'b1; pl3_addr = 5'd7; pl3_data = 16'hCAFE;
    tick();
    pl_en = 1'b0; pl3_en = 1'b0;
    tick();
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_en, ram_we, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_en, ram_we, busy});
    end
    checks++;
    if ({cpu_rdata, dbg_rdata, ram_addr, ram_wdata} !== 53'b0) begin
      failures++;
      $display("FAIL reset_data: got cpu_rdata=%h dbg_rdata=%h ram_addr=%h ram_wdata=%h want all 0",
               cpu_rdata, dbg_rdata, ram_addr, ram_wdata);
    end
    checks++;
    if ({l3_cpu_gnt, l3_dbg_gnt, l3_cpu_rvalid, l3_dbg_rvalid, l3_ram_en, l3_ram_we, l3_busy,
         l3_cpu_rdata, l3_dbg_rdata, l3_ram_addr, l3_ram_wdata} !== 60'b0) begin
      failures++;
      $display("FAIL reset_lat3: outputs of RAM_LAT=3 instance not all 0");
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    tick(); // cycle 1
    checks++;
    if ({cpu_gnt, dbg_gnt, ram_en, ram_we, busy} !== 5'b10101 || ram_addr !== 5'd5) begin
      failures++;
      $display("FAIL rd_access: got gnt/dgnt/en/we/busy=%b addr=%0d want 10101 addr=5",
               {cpu_gnt, dbg_gnt, ram_en, ram_we, busy}, ram_addr);
    end
    cpu_req = 1'b0;
    tick(); // cycle 2
    checks++;
    if ({cpu_gnt, ram_en, busy, cpu_rvalid} !== 4'b0010) begin
      failures++;
      $display("FAIL rd_wait: got gnt/en/busy/rvalid=%b want 0010", {cpu_gnt, ram_en, busy, cpu_rvalid});
    end
    tick(); // cycle 3
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL rd_rvalid: got rvalid=%b rdata=%h want 1 BEEF", cpu_rvalid, cpu_rdata);
    end
    checks++;
    if ({dbg_gnt, dbg_rvalid, dbg_rdata} !== 18'b0) begin
      failures++;
      $display("FAIL rd_dbg_quiet: got dgnt=%b drvalid=%b drdata=%h want 0 0 0",
               dbg_gnt, dbg_rvalid, dbg_rdata);
    end
    tick(); // cycle 4
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_hold: got rvalid=%b rdata=%h busy=%b want 0 BEEF 0", cpu_rvalid, cpu_rdata, busy);
    end
  endtask

  task automatic test_dbg_write_cpu_read();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 16'h1234;
    tick(); // cycle 1
    checks++;
    if ({dbg_gnt, cpu_gnt, ram_en, ram_we} !== 4'b1011 || ram_addr !== 5'd9 || ram_wdata !== 16'h1234) begin
      failures++;
      $display("FAIL wr_access: got dgnt/cgnt/en/we=%b addr=%0d wdata=%h want 1011 9 1234",
               {dbg_gnt, cpu_gnt, ram_en, ram_we}, ram_addr, ram_wdata);
    end
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
    tick(); // cycle 2: back in IDLE after the write
    checks++;
    if ({busy, ram_en, dbg_gnt} !== 3'b000 || ram_wdata !== 16'h1234) begin
      failures++;
      $display("FAIL wr_done: got busy/en/dgnt=%b wdata=%h want 000 1234", {busy, ram_en, dbg_gnt}, ram_wdata);
    end
    tick(); // cycle 3
    checks++;
    if ({cpu_gnt, ram_en, ram_we} !== 3'b110 || ram_addr !== 5'd9) begin
      failures++;
      $display("FAIL wr_rd_access: got gnt/en/we=%b addr=%0d want 110 9", {cpu_gnt, ram_en, ram_we}, ram_addr);
    end
    cpu_req = 1'b0;
    tick();
    tick(); // cycle 5
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234 || dbg_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_readback: got rvalid=%b rdata=%h drvalid=%b want 1 1234 0", cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] order;
    int         cyc[4];
    int         n = 0;
    int         both = 0;
    order = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd1; cpu_wdata = 16'h1111;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd2; dbg_wdata = 16'h2222;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (cpu_gnt && dbg_gnt) both++;
      if (cpu_gnt || dbg_gnt) begin
        order[n] = dbg_gnt;
        cyc[n] = c;
        n++;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    checks++;
    if (n !== 4 || both !== 0) begin
      failures++;
      $display("FAIL rr_count: got grants=%0d double=%0d want 4 0", n, both);
    end
    checks++;
    if (order !== 4'b1010) begin
      failures++;
      $display("FAIL rr_order: got dbg-bits(3..0)=%b want 1010 (CPU,DBG,CPU,DBG)", order);
    end
    checks++;
    if (n == 4 && cyc[3] - cyc[0] !== 6) begin
      failures++;
      $display("FAIL rr_throughput: got span=%0d cycles want 6", cyc[3] - cyc[0]);
    end
    tick();
    tick();
  endtask

  task automatic test_halt();
    logic [3:0] order;
    int         n = 0;
    order = '0;
    cpu_halt = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 16'h3333;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 16'h4444;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (cpu_gnt || dbg_gnt) begin
        order[n] = dbg_gnt;
        n++;
        if (n == 3) cpu_halt = 1'b0;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_halt = 1'b0;
    checks++;
    if (n !== 4 || order !== 4'b0111) begin
      failures++;
      $display("FAIL halt_order: got grants=%0d dbg-bits(3..0)=%b want 4 0111 (DBG,DBG,DBG,CPU)", n, order);
    end
    tick();
    tick();
  endtask

  task automatic test_lat3();
    int   busy_n;
    logic early_dbg = 1'b0;
    logic early_rv  = 1'b0;
    l3_cpu_req = 1'b1; l3_cpu_we = 1'b0; l3_cpu_addr = 5'd7;
    tick(); // cycle 1
    checks++;
    if ({l3_cpu_gnt, l3_ram_en, l3_ram_we} !== 3'b110 || l3_ram_addr !== 5'd7) begin
      failures++;
      $display("FAIL l3_access: got gnt/en/we=%b addr=%0d want 110 7", {l3_cpu_gnt, l3_ram_en, l3_ram_we}, l3_ram_addr);
    end
    busy_n = int'(l3_busy);
    l3_cpu_req = 1'b0;
    l3_dbg_req = 1'b1; l3_dbg_we = 1'b1; l3_dbg_addr = 5'd3; l3_dbg_wdata = 16'h5A5A;
    repeat (3) begin // cycles 2..4
      tick();
      busy_n += int'(l3_busy);
      early_dbg |= l3_dbg_gnt;
      early_rv  |= l3_cpu_rvalid;
    end
    tick(); // cycle 5
    early_dbg |= l3_dbg_gnt;
    checks++;
    if (l3_cpu_rvalid !== 1'b1 || l3_cpu_rdata !== 16'hCAFE || l3_busy !== 1'b0 || early_rv !== 1'b0) begin
      failures++;
      $display("FAIL l3_rvalid: got rvalid=%b rdata=%h busy=%b early_rvalid=%b want 1 CAFE 0 0",
               l3_cpu_rvalid, l3_cpu_rdata, l3_busy, early_rv);
    end
    checks++;
    if (busy_n !== 4) begin
      failures++;
      $display("FAIL l3_busy_len: got %0d busy cycles want 4", busy_n);
    end
    checks++;
    if (early_dbg !== 1'b0) begin
      failures++;
      $display("FAIL l3_dbg_early: got dbg_gnt during read want none");
    end
    tick(); // cycle 6
    checks++;
    if (l3_dbg_gnt !== 1'b1 || l3_ram_we !== 1'b1) begin
      failures++;
      $display("FAIL l3_dbg_gnt: got dgnt=%b we=%b want 1 1", l3_dbg_gnt, l3_ram_we);
    end
    l3_dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_midread();
    logic rv_seen = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    tick(); // cycle 1
    cpu_req = 1'b0;
    tick(); // cycle 2: WAIT
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got busy=%b want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_en, ram_we, busy, ram_addr} !== 12'b0) begin
      failures++;
      $display("FAIL mid_async: got ctrl=%b addr=%0d want all 0",
               {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_en, ram_we, busy}, ram_addr);
    end
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      rv_seen |= cpu_rvalid;
    end
    checks++;
    if (rv_seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_rvalid: got cpu_rvalid after reset want none");
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd10; cpu_wdata = 16'h0A0A;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd11; dbg_wdata = 16'h0B0B;
    tick();
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL mid_tie: got cgnt/dgnt=%b want 10", {cpu_gnt, dbg_gnt});
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write_cpu_read();
    test_round_robin();
    test_halt();
    test_lat3();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
